// File: rtl/syn_fifo_pkg.sv
// Shared definitions for the single-clock FIFO: read-mode constants and
// parameter legality helpers evaluated at elaboration time.
package syn_fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // almost_full threshold must lie inside 1..DEPTH
    function automatic bit af_level_legal(input int af, input int depth);
        return (af >= 1) && (af <= depth);
    endfunction

    // almost_empty threshold must lie inside 0..DEPTH-1
    function automatic bit ae_level_legal(input int ae, input int depth);
        return (ae >= 0) && (ae <= depth - 1);
    endfunction

    // only the two documented read modes exist
    function automatic bit fwft_mode_legal(input int mode);
        return (mode == FIFO_STD) || (mode == FIFO_FWFT);
    endfunction

endpackage

// File: rtl/syn_fifo_if.sv
// Push/pop handshake and status bundle between a producer/consumer and the FIFO.
interface syn_fifo_if #(
    parameter int WIDTH   = 8,
    parameter int POINTER = 3
);
    logic               wr_en;
    logic [WIDTH-1:0]   data_in;
    logic               rd_en;
    logic [WIDTH-1:0]   data_out;
    logic               data_valid;
    logic               wr_full;
    logic               rd_empty;
    logic               almost_full;
    logic               almost_empty;
    logic [POINTER:0]   count;
    logic               overflow;
    logic               underflow;

    // producer/consumer side
    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, data_valid, wr_full, rd_empty,
        input  almost_full, almost_empty, count, overflow, underflow
    );

    // FIFO side
    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, data_valid, wr_full, rd_empty,
        output almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/syn_fifo_ram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/syn_fifo.sv
// Single-clock FIFO with occupancy count, programmable almost thresholds,
// overflow/underflow pulses and a standard or first-word-fall-through read port.
module syn_fifo
    import syn_fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int POINTER  = 3,
    parameter int AF_LEVEL = (1 << POINTER) - 2,
    parameter int AE_LEVEL = 1,
    parameter int FWFT     = FIFO_STD
) (
    input  logic       clk,
    input  logic       reset,
    syn_fifo_if.slave  bus
);
    localparam int DEPTH = 1 << POINTER;

    localparam logic [POINTER:0] DEPTH_C = (POINTER+1)'(DEPTH);
    localparam logic [POINTER:0] AF_C    = (POINTER+1)'(AF_LEVEL);
    localparam logic [POINTER:0] AE_C    = (POINTER+1)'(AE_LEVEL);
    localparam logic [POINTER:0] ONE_C   = (POINTER+1)'(1);

    if (!af_level_legal(AF_LEVEL, DEPTH)) begin : g_bad_af
        $error("syn_fifo: AF_LEVEL out of range 1..DEPTH");
    end
    if (!ae_level_legal(AE_LEVEL, DEPTH)) begin : g_bad_ae
        $error("syn_fifo: AE_LEVEL out of range 0..DEPTH-1");
    end
    if (!fwft_mode_legal(FWFT)) begin : g_bad_mode
        $error("syn_fifo: FWFT must be FIFO_STD or FIFO_FWFT");
    end

    logic [POINTER:0] wr_ptr_q, wr_ptr_d;
    logic [POINTER:0] rd_ptr_q, rd_ptr_d;
    logic [POINTER:0] count_q,  count_d;
    logic [WIDTH-1:0] dout_q,   dout_d;
    logic             dvalid_q, dvalid_d;
    logic             ovf_q,    ovf_d;
    logic             unf_q,    unf_d;

    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;
    logic [WIDTH-1:0] ram_rdata;

    // flags come only from the registered count
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign push_ok = bus.wr_en && !full;
    assign pop_ok  = bus.rd_en && !empty;

    fifo_ram #(
        .WIDTH (WIDTH),
        .AW    (POINTER)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr_q[POINTER-1:0]),
        .wdata (bus.data_in),
        .raddr (rd_ptr_q[POINTER-1:0]),
        .rdata (ram_rdata)
    );

    // next-state for pointers, count, read register and error pulses
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        dvalid_d = pop_ok;
        ovf_d    = bus.wr_en && full;
        unf_d    = bus.rd_en && empty;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ONE_C;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + ONE_C;
            dout_d   = ram_rdata;
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase
    end

    // state registers; reset wins over any same-cycle push or pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // read port: registered word in standard mode, live head word in FWFT mode
    always_comb begin
        bus.data_out   = dout_q;
        bus.data_valid = dvalid_q;
        if (FWFT == FIFO_FWFT) begin
            bus.data_valid = !empty;
            bus.data_out   = empty ? '0 : ram_rdata;
        end
    end

    assign bus.wr_full      = full;
    assign bus.rd_empty     = empty;
    assign bus.almost_full  = (count_q >= AF_C);
    assign bus.almost_empty = (count_q <= AE_C);
    assign bus.count        = count_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_syn_fifo.sv
// Bench for syn_fifo: one standard-mode and one FWFT-mode instance driven with
// identical stimulus and compared against a queue-based reference model.
module tb_syn_fifo;

    localparam int WIDTH   = 8;
    localparam int POINTER = 3;
    localparam int DEPTH   = 1 << POINTER;
    localparam int AF      = DEPTH - 2;
    localparam int AE      = 1;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    syn_fifo_if #(.WIDTH(WIDTH), .POINTER(POINTER)) bus_std  ();
    syn_fifo_if #(.WIDTH(WIDTH), .POINTER(POINTER)) bus_fwft ();

    syn_fifo #(
        .WIDTH(WIDTH), .POINTER(POINTER), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
    ) u_std (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_std)
    );

    syn_fifo #(
        .WIDTH(WIDTH), .POINTER(POINTER), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
    ) u_fwft (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_fwft)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: contents as a queue plus the standard-mode output register
    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_dv   = 1'b0;
    logic             exp_ovf  = 1'b0;
    logic             exp_unf  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = model_q.size();
        chk("std.count",        32'(bus_std.count),        32'(sz));
        chk("std.wr_full",      32'(bus_std.wr_full),      32'(sz == DEPTH));
        chk("std.rd_empty",     32'(bus_std.rd_empty),     32'(sz == 0));
        chk("std.almost_full",  32'(bus_std.almost_full),  32'(sz >= AF));
        chk("std.almost_empty", 32'(bus_std.almost_empty), 32'(sz <= AE));
        chk("std.overflow",     32'(bus_std.overflow),     32'(exp_ovf));
        chk("std.underflow",    32'(bus_std.underflow),    32'(exp_unf));
        chk("std.data_valid",   32'(bus_std.data_valid),   32'(exp_dv));
        chk("std.data_out",     32'(bus_std.data_out),     32'(exp_dout));
        chk("fwft.count",       32'(bus_fwft.count),       32'(sz));
        chk("fwft.overflow",    32'(bus_fwft.overflow),    32'(exp_ovf));
        chk("fwft.underflow",   32'(bus_fwft.underflow),   32'(exp_unf));
        chk("fwft.data_valid",  32'(bus_fwft.data_valid),  32'(sz != 0));
        if (sz != 0) begin
            chk("fwft.data_out", 32'(bus_fwft.data_out), 32'(model_q[0]));
        end
    endtask

    // one clock cycle: drive at negedge, update model, check 1 time unit after posedge
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input logic rst);
        logic push_ok;
        logic pop_ok;
        @(negedge clk);
        reset            = rst;
        bus_std.wr_en    = w;
        bus_std.data_in  = d;
        bus_std.rd_en    = r;
        bus_fwft.wr_en   = w;
        bus_fwft.data_in = d;
        bus_fwft.rd_en   = r;
        if (rst) begin
            model_q.delete();
            exp_dout = '0;
            exp_dv   = 1'b0;
            exp_ovf  = 1'b0;
            exp_unf  = 1'b0;
        end else begin
            push_ok = w && (model_q.size() < DEPTH);
            pop_ok  = r && (model_q.size() > 0);
            exp_ovf = w && !push_ok;
            exp_unf = r && !pop_ok;
            exp_dv  = pop_ok;
            if (pop_ok) exp_dout = model_q.pop_front();
            if (push_ok) model_q.push_back(d);
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bus_std.wr_en = 1'b0;  bus_std.rd_en = 1'b0;  bus_std.data_in = '0;
        bus_fwft.wr_en = 1'b0; bus_fwft.rd_en = 1'b0; bus_fwft.data_in = '0;

        // reset, including a push request that must be ignored
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b1, 1'b1);

        // fill 0x10..0x17 back-to-back, then one push too many
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        step(1'b1, 8'h18, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // drain, then one pop too many (data_out must hold the last word)
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // steady state at count 4 across pointer wrap
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);

        // full with simultaneous push and pop
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);

        // empty with simultaneous push and pop
        for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h81, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // single word presented without rd_en, then consumed
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // reset mid-stream at count 5, then only new data may come out
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'hD1, 1'b0, 1'b0);
        step(1'b1, 8'hD2, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 99) < 50), 1'($urandom_range(0, 99) < 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
